// File: rtl/pwm_capture.sv
// Servo PWM receiver: measures the synchronized high time of pwm_in and recovers
// the 8-bit position code, with lock tracking and runt/overrun error strobes.
module pwm_capture #(
  parameter int MIN_CYCLES     = 50000,
  parameter int STEP_CYCLES    = 196,
  parameter int MAX_CYCLES     = 150000,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       pwm_in,
  output logic [7:0] pos,
  output logic       pos_valid,
  output logic       locked,
  output logic       err
);

  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam int SW = $clog2(STEP_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    HIGH_MIN,
    HIGH_STEP,
    OVERRUN
  } state_e;

  state_e        state_q;
  logic          s1_q, s2_q, s3_q;
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] step_q;
  logic [7:0]    code_q;
  logic [7:0]    pos_q;
  logic          pos_valid_q, err_q, locked_q;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          locked_d;

  logic          rise, fall, decode;
  logic [CW:0]   cnt_inc;
  logic [SW:0]   step_inc;

  assign rise     = s2_q & ~s3_q;
  assign fall     = ~s2_q & s3_q;
  assign decode   = (state_q == HIGH_STEP) && fall;
  assign cnt_inc  = {1'b0, cnt_q} + (CW+1)'(1);
  assign step_inc = {1'b0, step_q} + (SW+1)'(1);

  // NOTE: the synchronizer resets to 1 so a line that is already high when reset
  // releases looks like a pulse in progress, and IDLE waits for a genuine low.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value of its
      // neighbour, which is what turns these three lines into a shift chain.
      s1_q <= pwm_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      step_q      <= '0;
      code_q      <= '0;
      pos_q       <= '0;
      pos_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      pos_valid_q <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        IDLE: if (!s2_q) state_q <= ARMED;
        ARMED: begin
          if (rise) begin
            // The rise cycle is itself the first high cycle, so cnt holds W at fall.
            cnt_q   <= CW'(1);
            step_q  <= '0;
            code_q  <= '0;
            state_q <= HIGH_MIN;
          end
        end
        HIGH_MIN: begin
          if (fall) begin
            err_q   <= 1'b1;
            state_q <= ARMED;
          end else begin
            cnt_q <= cnt_inc[CW-1:0];
            if (cnt_inc == (CW+1)'(MIN_CYCLES)) begin
              step_q  <= '0;
              code_q  <= '0;
              state_q <= HIGH_STEP;
            end
          end
        end
        HIGH_STEP: begin
          if (fall) begin
            pos_q       <= code_q;
            pos_valid_q <= 1'b1;
            state_q     <= ARMED;
          end else if (cnt_inc > (CW+1)'(MAX_CYCLES)) begin
            err_q   <= 1'b1;
            state_q <= OVERRUN;
          end else begin
            cnt_q <= cnt_inc[CW-1:0];
            if (step_inc == (SW+1)'(STEP_CYCLES)) begin
              step_q <= '0;
              if (code_q != 8'hFF) code_q <= code_q + 8'd1;
            end else begin
              step_q <= step_inc[SW-1:0];
            end
          end
        end
        OVERRUN: if (!s2_q) state_q <= ARMED;
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    tmo_d    = tmo_q;
    locked_d = locked_q;
    if (decode) begin
      tmo_d = '0;
    end else if (tmo_q != TW'(TIMEOUT_CYCLES)) begin
      tmo_d = tmo_q + TW'(1);
    end
    if (decode) begin
      locked_d = 1'b1;
    end else if (tmo_d == TW'(TIMEOUT_CYCLES)) begin
      locked_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      tmo_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      tmo_q    <= tmo_d;
      locked_q <= locked_d;
    end
  end

  assign pos       = pos_q;
  assign pos_valid = pos_valid_q;
  assign locked    = locked_q;
  assign err       = err_q;

endmodule
